// File: rtl/prco_pkg.sv
// Shared constants and types for the PRCO core register file.
// Register width, select width and register count live here so every user agrees.
package prco_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 3;
  localparam int NREGS  = 1 << ADDR_W;

  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0] word_t;

endpackage

// File: rtl/prco_regs.sv
// PRCO general-purpose register file: 8 x 16 bits, two combinational read ports,
// one synchronous write port gated by the global enable, active-low sync reset.
module prco_regs
  import prco_pkg::*;
(
  input  logic      i_clk,
  input  logic      i_reset,
  input  logic      i_en,
  input  reg_addr_t i_sela,
  output word_t     q_data,
  input  reg_addr_t i_selb,
  output word_t     q_datb,
  input  logic      i_we,
  input  reg_addr_t i_seld,
  input  word_t     i_datd
);

  word_t            regs_reg [NREGS];
  logic [NREGS-1:0] wr_hit;

  // One-hot write decode; a stalled or idle cycle leaves every hit low,
  // so garbage on the select/data lines cannot disturb state.
  generate
    for (genvar gi = 0; gi < NREGS; gi++) begin : g_wr_dec
      assign wr_hit[gi] = i_en && i_we && (i_seld == reg_addr_t'(gi));
    end
  endgenerate

  always_ff @(posedge i_clk) begin
    for (int i = 0; i < NREGS; i++) begin
      if (!i_reset) begin
        regs_reg[i] <= '0;
      end else if (wr_hit[i]) begin
        regs_reg[i] <= i_datd;
      end
    end
  end

  // No write bypass: a same-cycle read of the destination sees the old value.
  assign q_data = regs_reg[i_sela];
  assign q_datb = regs_reg[i_selb];

endmodule

// File: tb/tb_prco_regs.sv
// Scoreboard bench for prco_regs: stimulus pushes expected read values from a
// plain array model, a negedge monitor pops and compares against both read ports.
module tb_prco_regs;
  import prco_pkg::*;

  logic      i_clk = 1'b0;
  logic      i_reset = 1'b0;
  logic      i_en = 1'b0;
  reg_addr_t i_sela = '0;
  reg_addr_t i_selb = '0;
  logic      i_we = 1'b0;
  reg_addr_t i_seld = '0;
  word_t     i_datd = '0;
  word_t     q_data;
  word_t     q_datb;

  prco_regs dut (
    .i_clk  (i_clk),
    .i_reset(i_reset),
    .i_en   (i_en),
    .i_sela (i_sela),
    .q_data (q_data),
    .i_selb (i_selb),
    .q_datb (q_datb),
    .i_we   (i_we),
    .i_seld (i_seld),
    .i_datd (i_datd)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    int sa;
    int sb;
    int ea;
    int eb;
  } exp_t;

  exp_t sb_q[$];
  int   model [8];
  bit   model_valid = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;
  bit   stim_done = 1'b0;

  // One cycle of stimulus: inputs settle just after the rising edge, the
  // expected read data is what the model holds before the next edge commits.
  task automatic drive(input bit rst_n, input bit en, input bit we, input int seld,
                       input int datd, input int sa, input int sb);
    exp_t e;
    @(posedge i_clk);
    #1;
    i_reset = rst_n;
    i_en    = en;
    i_we    = we;
    i_seld  = reg_addr_t'(seld);
    i_datd  = word_t'(datd);
    i_sela  = reg_addr_t'(sa);
    i_selb  = reg_addr_t'(sb);
    if (model_valid) begin
      e.sa = sa; e.sb = sb; e.ea = model[sa]; e.eb = model[sb];
      sb_q.push_back(e);
    end
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) model[i] = 0;
      model_valid = 1'b1;
    end else if (en && we) begin
      model[seld] = datd & 16'hFFFF;
    end
  endtask

  task automatic rd(input int sa, input int sb);
    drive(1'b1, 1'b1, 1'b0, 0, 0, sa, sb);
  endtask

  task automatic wr(input int seld, input int datd);
    drive(1'b1, 1'b1, 1'b1, seld, datd, 0, 0);
  endtask

  // Monitor: the read ports are always presenting data, so every scheduled
  // expectation is checked mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge i_clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        n_checks++;
        if (int'(q_data) != e.ea) begin
          n_fail++;
          $display("FAIL port_a sel=%0d got=%04h exp=%04h t=%0t", e.sa, q_data, e.ea, $time);
        end else begin
          $display("ok   port_a sel=%0d data=%04h", e.sa, q_data);
        end
        n_checks++;
        if (int'(q_datb) != e.eb) begin
          n_fail++;
          $display("FAIL port_b sel=%0d got=%04h exp=%04h t=%0t", e.sb, q_datb, e.eb, $time);
        end else begin
          $display("ok   port_b sel=%0d data=%04h", e.sb, q_datb);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout stim_done=%0d pending=%0d", stim_done, sb_q.size());
    $fatal(1, "watchdog expired");
  end

  initial begin
    // initial reset
    drive(1'b0, 1'b0, 1'b0, 0, 0, 0, 0);
    // 1: reset clears a previously written register, independent of i_en
    wr(3, 16'h1234);
    rd(3, 5);
    drive(1'b0, 1'b0, 1'b0, 0, 0, 3, 5);
    rd(3, 5);
    // 2: basic write/read
    wr(1, 16'hF0F0);
    rd(1, 0);
    rd(2, 7);
    // 3: enable gating
    drive(1'b1, 1'b0, 1'b1, 2, 16'hBEEF, 2, 2);
    drive(1'b1, 1'b0, 1'b1, 2, 16'hBEEF, 2, 2);
    rd(2, 1);
    drive(1'b1, 1'b1, 1'b1, 2, 16'hBEEF, 2, 2);
    rd(2, 2);
    // 4: dual read of the register being written, no bypass
    wr(4, 16'h0001);
    drive(1'b1, 1'b1, 1'b1, 4, 16'hAAAA, 4, 4);
    rd(4, 4);
    // 5: reset beats a simultaneous write
    wr(6, 16'h7777);
    drive(1'b0, 1'b1, 1'b1, 6, 16'h5555, 6, 0);
    rd(6, 3);
    // 6: sweep every register and every read pair
    for (int i = 0; i < 8; i++) wr(i, 16'h1000 + i);
    for (int a = 0; a < 8; a++)
      for (int b = 0; b < 8; b++) rd(a, b);
    // random traffic, occasional reset, random stalls
    for (int n = 0; n < 300; n++) begin
      drive(($urandom_range(0, 39) != 0), $urandom_range(0, 1), $urandom_range(0, 1),
            $urandom_range(0, 7), $urandom_range(0, 16'hFFFF),
            $urandom_range(0, 7), $urandom_range(0, 7));
    end
    rd(0, 7);
    @(posedge i_clk);
    @(negedge i_clk);
    @(negedge i_clk);
    stim_done = 1'b1;
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain pending=%0d exp=0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
